ahb_lite_rif_bridge: RTL and testbench

Parametrised AHB-Lite subordinate that bridges to the register interface (rif_*). It adds rif_ready wait-state handshaking, a timeout, size/alignment/security checking with the two-cycle AHB ERROR response, byte-strobe generation and back-to-back pipelined transfers. It sits between the AHB-Lite interconnect and a register file or peripheral register block.

---
 rtl/ahb_lite_rif_bridge.sv | 176 +++++++++++++++++
 tb/tb_ahb_lite_rif_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_rif_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_rif_bridge
// Description : AHB-Lite subordinate bridging to a simple register interface.
//               Adds rif_ready wait states, a wait timeout, size/alignment/
//               security checking with the two-cycle ERROR response, byte
//               strobes and back-to-back pipelined transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_rif_bridge #(
  parameter int   ADDR_WIDTH     = 12,
  parameter int   DATA_WIDTH     = 32,
  parameter logic SEC_TRANS      = 1'b0,
  parameter int   TIMEOUT_CYCLES = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic                    HSEL,
  input  logic                    HNONSEC,
  input  logic [2:0]              HBURST,
  input  logic [2:0]              HSIZE,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HRESP,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic [ADDR_WIDTH-1:0]   rif_addr,
  input  logic                    rif_addr_valid,
  output logic                    rif_wr_req,
  output logic                    rif_rd_req,
  output logic [DATA_WIDTH/8-1:0] rif_wstrb,
  output logic [DATA_WIDTH-1:0]   rif_wdata,
  input  logic [DATA_WIDTH-1:0]   rif_rdata,
  input  logic                    rif_ready
);

  localparam int c_strb_w   = DATA_WIDTH / 8;
  localparam int c_max_size = $clog2(c_strb_w);
  localparam int c_lane_w   = (c_max_size > 0) ? c_max_size : 1;
  localparam int c_cnt_w    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_to_last =
    (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  // Parameter legality is checked at elaboration
  if ((DATA_WIDTH < 8) || (DATA_WIDTH > 1024) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_data_width
    $fatal(1, "ahb_lite_rif_bridge: DATA_WIDTH must be a power of two in 8..1024");
  end
  if ((TIMEOUT_CYCLES < 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $fatal(1, "ahb_lite_rif_bridge: TIMEOUT_CYCLES must be in 0..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR1   = 2'd2,
    S_ERR2   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [2:0]              r_size;
  logic [c_cnt_w-1:0]      r_cnt;

  logic                    w_capture;
  logic                    w_check_ok;
  logic [ADDR_WIDTH-1:0]   w_align_mask;
  logic                    w_in_access;
  logic                    w_done;
  logic                    w_timeout;
  logic                    w_take;
  logic [c_lane_w-1:0]     w_lane;
  logic [c_strb_w-1:0]     w_size_mask;
  logic                    w_unused;

  // HBURST is ignored (each beat is independent); HTRANS[0] does not affect capture
  assign w_unused = ^{HBURST, HTRANS[0]};

  assign w_capture    = HSEL & HREADY & HTRANS[1];
  assign w_align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
  assign w_check_ok   = (HSIZE <= 3'(c_max_size))
                      & ((HADDR & w_align_mask) == '0)
                      & ~(SEC_TRANS & HNONSEC);

  assign w_in_access = (r_state == S_ACCESS);
  assign w_done      = w_in_access & rif_addr_valid & rif_ready;
  assign w_timeout   = (TIMEOUT_CYCLES > 0) & w_in_access & rif_addr_valid
                     & ~rif_ready & (r_cnt == c_to_last);
  // A new address phase is accepted whenever the data phase is not stalling
  assign w_take      = w_capture & ((r_state == S_IDLE) | (r_state == S_ERR2) | w_done);

  // Byte-lane offset; an 8-bit bus has a single lane and no offset bits
  if (c_max_size > 0) begin : g_lane_multi
    assign w_lane = r_addr[c_lane_w-1:0];
  end else begin : g_lane_single
    assign w_lane = '0;
  end

  // Contiguous run of (1 << size) enabled lanes starting at lane 0
  always_comb begin
    w_size_mask = '0;
    for (int i = 0; i < c_strb_w; i++) begin
      w_size_mask[i] = (i < (1 << r_size));
    end
  end

  // Transfer state machine, latched transfer attributes and wait counter
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_cnt <= '0;
      if (w_check_ok) begin
        r_state <= S_ACCESS;
        r_addr  <= HADDR;
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end else begin
        r_state <= S_ERR1;
      end
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_ACCESS: begin
          if (!rif_addr_valid) begin
            r_state <= S_ERR1;
          end else if (rif_ready) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_state <= S_ERR1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        S_ERR2:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // AHB response: zero-wait completion comes straight from rif_ready
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (r_state)
      S_IDLE:   HREADYOUT = 1'b1;
      S_ACCESS: HREADYOUT = w_done;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: HREADYOUT = 1'b1;
    endcase
  end

  assign HRDATA     = (w_done & ~r_write) ? rif_rdata : '0;
  assign rif_addr   = r_addr;
  assign rif_wr_req = w_in_access & rif_addr_valid & r_write;
  assign rif_rd_req = w_in_access & rif_addr_valid & ~r_write;
  assign rif_wdata  = w_in_access ? HWDATA : '0;
  assign rif_wstrb  = (w_in_access & r_write) ? (w_size_mask << w_lane) : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_rif_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_rif_bridge
// Description : Directed self-checking bench for ahb_lite_rif_bridge
//               (32-bit bus, SEC_TRANS=1, TIMEOUT_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_rif_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] HADDR;
  logic        HSEL;
  logic        HNONSEC;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADY;
  logic        HREADYOUT;
  logic [11:0] rif_addr;
  logic        rif_addr_valid;
  logic        rif_wr_req;
  logic        rif_rd_req;
  logic [3:0]  rif_wstrb;
  logic [31:0] rif_wdata;
  logic [31:0] rif_rdata;
  logic        rif_ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Single subordinate on the bus: HREADY follows this subordinate
  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_lite_rif_bridge #(
    .ADDR_WIDTH    (12),
    .DATA_WIDTH    (32),
    .SEC_TRANS     (1'b1),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HADDR         (HADDR),
    .HSEL          (HSEL),
    .HNONSEC       (HNONSEC),
    .HBURST        (HBURST),
    .HSIZE         (HSIZE),
    .HTRANS        (HTRANS),
    .HWRITE        (HWRITE),
    .HWDATA        (HWDATA),
    .HRDATA        (HRDATA),
    .HRESP         (HRESP),
    .HREADY        (HREADY),
    .HREADYOUT     (HREADYOUT),
    .rif_addr      (rif_addr),
    .rif_addr_valid(rif_addr_valid),
    .rif_wr_req    (rif_wr_req),
    .rif_rd_req    (rif_rd_req),
    .rif_wstrb     (rif_wstrb),
    .rif_wdata     (rif_wdata),
    .rif_rdata     (rif_rdata),
    .rif_ready     (rif_ready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive at the falling edge; outputs are sampled 1 time unit later
  task automatic cyc();
    @(negedge HCLK);
  endtask

  task automatic addr_phase(input logic [11:0] a, input logic w, input logic [2:0] sz, input logic ns);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz; HNONSEC = ns;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HNONSEC = 1'b0;
  endtask

  // One transfer completing with zero wait states
  task automatic xfer(input string tag, input logic [11:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] exp_strb);
    cyc();
    addr_phase(a, w, sz, 1'b0);
    #1 chk({tag, "_aphase_rdy"}, HREADYOUT, 1);
    cyc();
    bus_idle();
    HWDATA = wd; rif_rdata = rd; rif_ready = 1'b1; rif_addr_valid = 1'b1;
    #1;
    chk({tag, "_wr_req"}, rif_wr_req, w);
    chk({tag, "_rd_req"}, rif_rd_req, !w);
    chk({tag, "_addr"}, rif_addr, a);
    chk({tag, "_wstrb"}, rif_wstrb, exp_strb);
    chk({tag, "_rdy"}, HREADYOUT, 1);
    chk({tag, "_resp"}, HRESP, 0);
    if (w) chk({tag, "_wdata"}, rif_wdata, wd);
    else   chk({tag, "_hrdata"}, HRDATA, rd);
    cyc();
    #1;
    chk({tag, "_req_drop"}, {rif_wr_req, rif_rd_req}, 2'b00);
  endtask

  // Transfer expected to end in the two-cycle ERROR with no rif request
  task automatic err_xfer(input string tag, input logic [11:0] a, input logic w, input logic [2:0] sz,
                          input logic ns, input logic valid, input int exp_lat);
    int   k;
    logic seen;
    cyc();
    addr_phase(a, w, sz, ns);
    cyc();
    bus_idle();
    rif_ready = 1'b1; rif_addr_valid = valid;
    #1;
    k = 0;
    seen = rif_wr_req | rif_rd_req;
    while (k < 5 && !(HRESP && !HREADYOUT)) begin
      cyc(); #1;
      seen |= rif_wr_req | rif_rd_req;
      k++;
    end
    chk({tag, "_err_lat"}, k, exp_lat);
    chk({tag, "_err1_resp"}, HRESP, 1);
    chk({tag, "_err1_rdy"}, HREADYOUT, 0);
    cyc(); #1;
    seen |= rif_wr_req | rif_rd_req;
    chk({tag, "_err2_resp"}, HRESP, 1);
    chk({tag, "_err2_rdy"}, HREADYOUT, 1);
    chk({tag, "_no_req"}, seen, 0);
    rif_addr_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi;
    int k;
    HRESET = 1'b1; HADDR = '0; HSEL = 1'b0; HNONSEC = 1'b0; HBURST = 3'b000;
    HSIZE = 3'd0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
    rif_addr_valid = 1'b1; rif_rdata = '0; rif_ready = 1'b1;

    // Reset values
    cyc(); cyc();
    #1;
    chk("rst_rdy", HREADYOUT, 1);
    chk("rst_resp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_addr", rif_addr, 0);
    chk("rst_reqs", {rif_wr_req, rif_rd_req}, 0);
    chk("rst_wstrb", rif_wstrb, 0);
    chk("rst_wdata", rif_wdata, 0);
    cyc();
    HRESET = 1'b0;

    // Zero-wait writes/read and strobe patterns
    xfer("wr_word", 12'h010, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 4'b1111);
    xfer("wr_byte", 12'h013, 1'b1, 3'd0, 32'hAB000000, 32'h0, 4'b1000);
    xfer("wr_half", 12'h012, 1'b1, 3'd1, 32'h55660000, 32'h0, 4'b1100);
    xfer("rd_word", 12'h010, 1'b0, 3'd2, 32'h0, 32'hCAFE0001, 4'b0000);

    // Read with three wait states
    cyc();
    addr_phase(12'h020, 1'b0, 3'd2, 1'b0);
    cyc();
    bus_idle();
    rif_ready = 1'b0; rif_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_rdy_low", HREADYOUT, 0);
      chk("wait_rd_req", rif_rd_req, 1);
      chk("wait_hrdata", HRDATA, 0);
      cyc();
    end
    rif_ready = 1'b1; rif_rdata = 32'h12345678;
    #1;
    chk("wait_done_rdy", HREADYOUT, 1);
    chk("wait_done_hrdata", HRDATA, 32'h12345678);
    chk("wait_done_resp", HRESP, 0);

    // Timeout with rif_ready stuck low
    cyc();
    addr_phase(12'h030, 1'b0, 3'd2, 1'b0);
    cyc();
    bus_idle();
    rif_ready = 1'b0;
    #1;
    n_hi = 0; k = 0;
    while (k < 40 && rif_rd_req) begin
      n_hi++;
      cyc(); #1;
      k++;
    end
    chk("to_req_cycles", n_hi, 16);
    chk("to_err1_rdy", HREADYOUT, 0);
    chk("to_err1_resp", HRESP, 1);
    cyc(); #1;
    chk("to_err2_rdy", HREADYOUT, 1);
    chk("to_err2_resp", HRESP, 1);
    chk("to_err2_req", rif_rd_req, 0);
    rif_ready = 1'b1;

    // Checked-error transfers
    err_xfer("misalign", 12'h011, 1'b1, 3'd1, 1'b0, 1'b1, 0);
    err_xfer("size3",    12'h010, 1'b0, 3'd3, 1'b0, 1'b1, 0);
    err_xfer("nonsec",   12'h010, 1'b0, 3'd2, 1'b1, 1'b1, 0);
    err_xfer("addr_inv", 12'h040, 1'b1, 3'd2, 1'b0, 1'b0, 1);

    // Back-to-back: write 0x004 then read 0x008 pipelined
    cyc();
    addr_phase(12'h004, 1'b1, 3'd2, 1'b0);
    cyc();
    addr_phase(12'h008, 1'b0, 3'd2, 1'b0);
    HWDATA = 32'h11223344; rif_ready = 1'b1; rif_rdata = 32'h0;
    #1;
    chk("b2b_wr_req", rif_wr_req, 1);
    chk("b2b_wr_addr", rif_addr, 12'h004);
    chk("b2b_wr_wdata", rif_wdata, 32'h11223344);
    chk("b2b_wr_rdy", HREADYOUT, 1);
    cyc();
    bus_idle();
    rif_rdata = 32'hA5A55A5A;
    #1;
    chk("b2b_rd_req", {rif_wr_req, rif_rd_req}, 2'b01);
    chk("b2b_rd_addr", rif_addr, 12'h008);
    chk("b2b_rd_rdy", HREADYOUT, 1);
    chk("b2b_rd_hrdata", HRDATA, 32'hA5A55A5A);

    // Reset while waiting in ACCESS
    cyc();
    addr_phase(12'h050, 1'b0, 3'd2, 1'b0);
    cyc();
    bus_idle();
    rif_ready = 1'b0;
    #1;
    chk("rstw_wait_rdy", HREADYOUT, 0);
    chk("rstw_wait_req", rif_rd_req, 1);
    HRESET = 1'b1;
    cyc(); #1;
    chk("rstw_rdy", HREADYOUT, 1);
    chk("rstw_resp", HRESP, 0);
    chk("rstw_reqs", {rif_wr_req, rif_rd_req}, 0);
    chk("rstw_addr", rif_addr, 0);
    chk("rstw_hrdata", HRDATA, 0);
    chk("rstw_wstrb", rif_wstrb, 0);
    HRESET = 1'b0;
    rif_ready = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
